// File: rtl/dm_store_buffer_pkg.sv
// Shared types and helpers for the data-memory store buffer.
package dm_store_buffer_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Who owns the single data-memory port this cycle.
    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_LOAD       = 2'd1,
        ARB_DRAIN      = 2'd2,
        ARB_LOAD_STALL = 2'd3
    } arb_e;

    // Expand byte enables into a 32-bit lane mask.
    function automatic logic [WORD_W-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // Overlay the enabled lanes of new_word onto old_word.
    function automatic logic [WORD_W-1:0] merge_lanes(input logic [WORD_W-1:0] new_word,
                                                      input logic [WORD_W-1:0] old_word,
                                                      input logic [BE_W-1:0]   be);
        logic [WORD_W-1:0] m;
        m = be_mask(be);
        return (new_word & m) | (old_word & ~m);
    endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// Store, load and data-memory signals of the store buffer.
// slave = the buffer itself; master = the surrounding pipeline and memory.
interface dm_store_buffer_if
    import dm_store_buffer_pkg::*;
#(
    parameter int AW = 10,
    parameter int CW = 3
);
    logic              st_valid;
    logic              st_ready;
    logic [31:0]       st_addr;
    logic [WORD_W-1:0] st_data;
    logic [BE_W-1:0]   st_be;

    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic [WORD_W-1:0] ld_data;
    logic              ld_stall;

    logic [AW-1:0]     dm_addr;
    logic [WORD_W-1:0] dm_din;
    logic              dm_we;
    logic [WORD_W-1:0] dm_dout;

    logic              empty;
    logic [CW-1:0]     count;

    modport slave (
        input  st_valid, st_addr, st_data, st_be,
        input  ld_valid, ld_addr,
        input  dm_dout,
        output st_ready, ld_data, ld_stall,
        output dm_addr, dm_din, dm_we,
        output empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, st_be,
        output ld_valid, ld_addr,
        output dm_dout,
        input  st_ready, ld_data, ld_stall,
        input  dm_addr, dm_din, dm_we,
        input  empty, count
    );

endinterface

// File: rtl/dm_store_buffer_sb_fwd_merge.sv
// Load forwarding: per byte lane, take the youngest pending store that hits
// the load word and enables that lane; otherwise keep the memory lane.
module sb_fwd_merge
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int CW    = 3,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]     ent_waddr [DEPTH],
    input  logic [WORD_W-1:0] ent_data  [DEPTH],
    input  logic [BE_W-1:0]   ent_be    [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [CW-1:0]     count,
    input  logic [AW-1:0]     ld_waddr,
    input  logic [WORD_W-1:0] mem_word,
    output logic [WORD_W-1:0] merged
);

    // Walk entries oldest to youngest so a later hit overwrites an earlier one.
    always_comb begin
        logic [PW-1:0] idx;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        merged = mem_word;
        idx    = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (ent_waddr[idx] == ld_waddr)) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (ent_be[idx][i]) begin
                        merged[8*i +: 8] = ent_data[idx][8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write buffer in front of the word-only data memory: FIFO of byte-
// enabled stores drained by read-modify-write, loads served with forwarding.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int CW    = 3
) (
    input  logic           clk,
    input  logic           reset,
    dm_store_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [AW-1:0]     ent_waddr_q [DEPTH];
    logic [WORD_W-1:0] ent_data_q  [DEPTH];
    logic [BE_W-1:0]   ent_be_q    [DEPTH];

    arb_e              arb;
    logic              full;
    logic              st_ready;
    logic              enq;
    logic              drain;
    logic [AW-1:0]     st_waddr;
    logic [AW-1:0]     ld_waddr;
    logic [WORD_W-1:0] fwd_word;

    assign st_waddr = bus.st_addr[AW+1:2];
    assign ld_waddr = bus.ld_addr[AW+1:2];
    assign full     = (count_q == CW'(DEPTH));
    assign st_ready = !full;
    assign enq      = bus.st_valid && st_ready;

    // Arbitrate the single memory port on pre-edge state; a full buffer drains even under a load.
    always_comb begin
        arb = ARB_IDLE;
        if (bus.ld_valid && full) begin
            arb = ARB_LOAD_STALL;
        end else if (bus.ld_valid) begin
            arb = ARB_LOAD;
        end else if (count_q != '0) begin
            arb = ARB_DRAIN;
        end
    end

    assign drain = (arb == ARB_DRAIN) || (arb == ARB_LOAD_STALL);

    // Next pointer and occupancy values from the enqueue/drain pair.
    always_comb begin
        head_d  = head_q + PW'(drain);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q;
        unique case ({enq, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all pending entries.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage written at the tail on enqueue.
    // NOTE: entry payload is left unreset; only count decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_waddr_q[tail_q] <= st_waddr;
            ent_data_q[tail_q]  <= bus.st_data;
            ent_be_q[tail_q]    <= bus.st_be;
        end
    end

    sb_fwd_merge #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW),
        .PW    (PW)
    ) u_fwd (
        .ent_waddr (ent_waddr_q),
        .ent_data  (ent_data_q),
        .ent_be    (ent_be_q),
        .head      (head_q),
        .count     (count_q),
        .ld_waddr  (ld_waddr),
        .mem_word  (bus.dm_dout),
        .merged    (fwd_word)
    );

    assign bus.dm_addr  = drain ? ent_waddr_q[head_q] : ld_waddr;
    assign bus.dm_din   = merge_lanes(ent_data_q[head_q], bus.dm_dout, ent_be_q[head_q]);
    assign bus.dm_we    = drain;
    assign bus.ld_data  = fwd_word;
    assign bus.ld_stall = (arb == ARB_LOAD_STALL);
    assign bus.st_ready = st_ready;
    assign bus.empty    = (count_q == '0);
    assign bus.count    = count_q;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios then random
// traffic, all against a queue-based reference model and reference memory.
module tb_dm_store_buffer;
    import dm_store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_store_buffer_if #(.AW(AW), .CW(CW)) bus ();

    dm_store_buffer #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory: asynchronous read, write on the clock edge.
    logic [31:0] mem [1024] = '{default: 32'h0};
    assign bus.dm_dout = mem[bus.dm_addr];
    always @(posedge clk) begin
        if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_din;
    end

    // Reference model: pending stores in program order plus expected memory.
    typedef struct {
        logic [AW-1:0] waddr;
        logic [31:0]   data;
        logic [3:0]    be;
    } st_t;
    st_t         q[$];
    logic [31:0] ref_mem [1024];

    int total = 0;
    int bad   = 0;

    logic        obs_we, obs_stall, obs_ready, obs_empty;
    logic [31:0] obs_addr, obs_din, obs_ld, obs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory word with every pending store laid over it, oldest first.
    function automatic logic [31:0] overlay(input logic [AW-1:0] a);
        logic [31:0] w;
        w = ref_mem[a];
        foreach (q[k]) begin
            if (q[k].waddr == a) begin
                for (int l = 0; l < 4; l++) begin
                    if (q[k].be[l]) w[8*l +: 8] = q[k].data[8*l +: 8];
                end
            end
        end
        return w;
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic [3:0] sbe, input logic lv, input logic [31:0] la);
        int          cnt;
        logic        stall, drn;
        logic [AW-1:0] exp_addr;
        logic [31:0] nw;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.st_be    = sbe;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        @(negedge clk);
        obs_we    = bus.dm_we;
        obs_stall = bus.ld_stall;
        obs_ready = bus.st_ready;
        obs_empty = bus.empty;
        obs_addr  = 32'(bus.dm_addr);
        obs_din   = bus.dm_din;
        obs_ld    = bus.ld_data;
        obs_cnt   = 32'(bus.count);

        cnt   = q.size();
        stall = lv && (cnt == DEPTH);
        drn   = (cnt > 0) && (!lv || cnt == DEPTH);
        chk("count",    obs_cnt, 32'(cnt));
        chk("empty",    32'(obs_empty), 32'(cnt == 0));
        chk("st_ready", 32'(obs_ready), 32'(cnt < DEPTH));
        chk("ld_stall", 32'(obs_stall), 32'(stall));
        chk("dm_we",    32'(obs_we), 32'(drn));
        exp_addr = drn ? q[0].waddr : la[AW+1:2];
        chk("dm_addr",  obs_addr, 32'(exp_addr));
        if (lv && !stall) chk("ld_data", obs_ld, overlay(la[AW+1:2]));
        if (drn) begin
            nw = ref_mem[q[0].waddr];
            for (int l = 0; l < 4; l++) begin
                if (q[0].be[l]) nw[8*l +: 8] = q[0].data[8*l +: 8];
            end
            chk("dm_din", obs_din, nw);
            ref_mem[q[0].waddr] = nw;
            void'(q.pop_front());
        end
        if (sv && cnt < DEPTH) q.push_back('{waddr: sa[AW+1:2], data: sd, be: sbe});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) idle();
        chk("drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] r2;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_be    = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        #12;
        chk("rst_count",    32'(bus.count), 32'd0);
        chk("rst_empty",    32'(bus.empty), 32'd1);
        chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
        chk("rst_dm_we",    32'(bus.dm_we), 32'd0);
        chk("rst_ld_stall", 32'(bus.ld_stall), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Word store then drain.
        step(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        idle();
        chk("word_we",   32'(obs_we), 32'd1);
        chk("word_addr", obs_addr, 32'd4);
        chk("word_din",  obs_din, 32'hDEADBEEF);
        idle();
        chk("word_empty", 32'(obs_empty), 32'd1);

        // Byte read-modify-write.
        step(1'b1, 32'h10, 32'h11223344, 4'hF, 1'b0, 32'h0);
        idle();
        step(1'b1, 32'h10, 32'h0000AA00, 4'h2, 1'b0, 32'h0);
        idle();
        chk("rmw_din", obs_din, 32'h1122AA44);

        // Forwarding, youngest store wins per lane.
        step(1'b1, 32'h20, 32'hCAFEBABE, 4'hF, 1'b0, 32'h0);
        idle();
        step(1'b1, 32'h20, 32'h000000FF, 4'h1, 1'b1, 32'h20);
        step(1'b1, 32'h20, 32'h00001234, 4'h3, 1'b1, 32'h20);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20);
        chk("fwd_data", obs_ld, 32'hCAFE1234);
        chk("fwd_cnt",  obs_cnt, 32'd2);
        chk("fwd_we",   32'(obs_we), 32'd0);
        drain_all();

        // Fill to full under loads, then the stall cycle drains the oldest.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h30 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 4'hF, 1'b1, 32'h100);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100);
        chk("full_ready", 32'(obs_ready), 32'd0);
        chk("full_stall", 32'(obs_stall), 32'd1);
        chk("full_we",    32'(obs_we), 32'd1);
        chk("full_addr",  obs_addr, 32'd12);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100);
        chk("after_stall", 32'(obs_stall), 32'd0);
        chk("after_cnt",   obs_cnt, 32'd3);
        chk("after_ready", 32'(obs_ready), 32'd1);
        drain_all();

        // Simultaneous enqueue and drain at count 2, running through wrap-around.
        step(1'b1, 32'h60, 32'h5555_0001, 4'hF, 1'b1, 32'h0);
        step(1'b1, 32'h64, 32'h5555_0002, 4'hC, 1'b1, 32'h0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            step(1'b1, 32'h80 + 32'(4 * (i % 3)), 32'h7700_0000 + 32'(i), 4'hF >> (i % 4), 1'b0, 32'h0);
            chk("simul_cnt", obs_cnt, 32'd2);
        end
        drain_all();

        // Reset mid-cycle with three pending entries.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h40 + 32'(4 * i), 32'hBAD0_0000 + 32'(i), 4'hF, 1'b1, 32'h0);
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b0;
        #2;
        chk("pre_rst_we", 32'(bus.dm_we), 32'd1);
        reset = 1'b1;
        #1;
        q.delete();
        chk("mid_rst_we",    32'(bus.dm_we), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_ready", 32'(bus.st_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 16; i < 19; i++) chk("rst_no_write", mem[i], ref_mem[i]);
        idle();

        // Random traffic over a small address window to provoke hits and fills.
        for (int n = 0; n < 600; n++) begin
            logic sv, lv;
            int   w, lw;
            r  = $urandom();
            r2 = $urandom();
            w  = $urandom_range(0, 7);
            lw = $urandom_range(0, 7);
            if (n < 300) begin
                sv = ($urandom_range(0, 1) == 1);
                lv = ($urandom_range(0, 2) == 0);
            end else begin
                sv = ($urandom_range(0, 9) != 0);
                lv = ($urandom_range(0, 9) < 7);
            end
            step(sv, {r[31:12], 10'(w), r[1:0]}, $urandom(), 4'($urandom_range(0, 15)),
                 lv, {r2[31:12], 10'(lw), r2[1:0]});
        end
        drain_all();
        for (int i = 0; i < 40; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
